mem_port_ctrl: RTL and testbench
================================

# mem_port_ctrl

Multicycle memory port sitting directly downstream of the main control FSM: it consumes `IorD`, `MemRead`, `MemWrite` and `IRWrite`, and runs one access at a time against an external handshaked memory. It also holds the Instruction Register (IR) and Memory Data Register (MDR). A registered `Busy` flag lets the controller stall, and a sticky `Fault` flag reports illegal or timed-out accesses.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: data word width.
- `TIMEOUT`, default 15: maximum number of cycles spent waiting for `MemAck`; must be ≥1.

- `clk`  in  1  sole clock; everything is updated on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `IorD`  in  1  address select: 0 selects `PC`, 1 selects `ALUOut`.
- `MemRead`  in  1  read request from control.
- `MemWrite`  in  1  write request from control.
- `IRWrite`  in  1  on a read, also load the returned word into IR.
- `PC`  in  ADDR_W  instruction address.
- `ALUOut`  in  ADDR_W  data address.
- `WriteData`  in  DATA_W  store data (B register).
- `Instr`  out  DATA_W  IR contents.
- `MemData`  out  DATA_W  MDR contents.
- `Busy`  out  1  access in flight.
- `Fault`  out  1  sticky error flag; cleared only by `rst`.
- `MemReq`  out  1  external request.
- `MemWe`  out  1  external write enable, valid while `MemReq`=1.
- `MemAddr`  out  ADDR_W  external byte address.
- `MemWdata`  out  DATA_W  external write data.
- `MemAck`  in  1  completion; read data is valid on the same cycle.
- `MemRdata`  in  DATA_W  external read data.

## Operation
- **Reset.** Every output and register goes to 0: `Instr`, `MemData`, `Busy`, `Fault`, `MemReq`, `MemWe`, `MemAddr` and `MemWdata`. The state becomes IDLE and the timeout counter is 0.
- **States.** There are two states, IDLE and WAIT.
- **IDLE, no request.** If `MemRead`=`MemWrite`=0, stay in IDLE.
- **IDLE, single request.** If exactly one of `MemRead`/`MemWrite` is 1:
  - latch `MemAddr` = `IorD` ? `ALUOut` : `PC`;
  - latch `MemWdata` = `WriteData` and `MemWe` = `MemWrite`;
  - set an internal IR-load flag = `IRWrite` & `MemRead`;
  - set `MemReq`=1 and `Busy`=1, clear the counter, and go to WAIT.
- **IDLE, both requests.** If `MemRead`=`MemWrite`=1 the request is illegal: set `Fault`=1, issue no request, and stay in IDLE.
- **WAIT, acknowledged.** If `MemAck`=1:
  - on a read, load MDR ← `MemRdata`, and also IR ← `MemRdata` when the IR-load flag is set;
  - on a write, leave IR and MDR unchanged;
  - clear `MemReq`, `Busy` and `MemWe`, and go to IDLE.
- **WAIT, no ack, counter below limit.** If `MemAck`=0 and counter < `TIMEOUT`-1, increment the counter.
- **WAIT, no ack, counter at limit.** If `MemAck`=0 and counter = `TIMEOUT`-1, abort:
  - set `Fault`=1 and clear `MemReq`, `Busy` and `MemWe`;
  - leave IR and MDR unchanged, and go to IDLE.
- **Ignored inputs.** `MemRead`, `MemWrite`, `IorD` and `IRWrite` are ignored while in WAIT, so a request raised during `Busy` is dropped. `MemAck` is ignored while in IDLE.
- **Stable outputs.** `MemAddr`, `MemWdata` and `MemWe` hold stable for the whole WAIT period. Input changes during WAIT do not affect them.
- **IR hold.** IR changes only on an acknowledged read with the IR-load flag set. MDR changes only on an acknowledged read.

## Timing
- A request is sampled at edge N. `MemReq`, `Busy` and `MemAddr` are valid after edge N, during cycle N+1.
- **Zero-wait memory** (`MemAck`=1 in cycle N+1): IR/MDR update at edge N+1, and `Busy` falls after edge N+1. The total latency is 2 edges.
- **k-wait memory:** IR/MDR update at edge N+1+k.
- **Timeout:**
  - an ack in the `TIMEOUT`-th WAIT cycle is a success;
  - with no ack by then, `Fault` rises and `Busy` falls after edge N+`TIMEOUT`.
- **Back-to-back requests:** a new request can be accepted at the edge following completion (the first IDLE cycle). The minimum spacing is therefore 2 cycles per access.
- **Reset mid-access:** `rst` has priority. A `rst` during WAIT aborts the access with no IR/MDR update, even if `MemAck`=1 in the same cycle, and `MemReq` is 0 after that edge.

## Configuration
- **Macro:** `MEM_PORT_ALIGN_CHECK_EN`.
- **Defined:** in IDLE, a request whose selected address has [1:0]≠0 is rejected. It sets `Fault`=1, issues no request and stays in IDLE. This check is applied before the both-requests check.
- **Undefined:** there is no alignment check. `MemAddr`[1:0] is forced to 0, so the access is word-aligned by truncation.

## Test plan
- **Zero-wait instruction fetch:** `PC`=0x40, `IorD`=0, `MemRead`=1, `IRWrite`=1; `MemAck`=1 in the first WAIT cycle with `MemRdata`=0x8C220004 -> `MemAddr`=0x40, and `Instr`=`MemData`=0x8C220004 after 2 edges, `Busy` pulses 1 cycle.
- **Store with 3 wait cycles:** `ALUOut`=0x100, `IorD`=1, `MemWrite`=1, `WriteData`=0xDEADBEEF; ack in the 4th WAIT cycle -> `MemWe`=1, `MemWdata` stable for 4 cycles, `Instr`/`MemData` unchanged, `Fault`=0.
- **Timeout:** `TIMEOUT`=15, no ack -> `Fault`=1 and `Busy`=0 after edge N+15, `MemData` unchanged. A repeat run with ack in WAIT cycle 15 -> success, `Fault`=0.
- **Illegal and ignored requests:** `MemRead`=`MemWrite`=1 -> no `MemReq`, `Fault`=1. A request raised mid-WAIT -> ignored, exactly one `MemReq` episode.
- **Reset mid-access:** `rst` asserted in WAIT together with `MemAck`=1 -> `MemData`=0, `MemReq`=0, state IDLE, `Fault`=0.
- **Alignment:** `ALUOut`=0x102 read -> with `MEM_PORT_ALIGN_CHECK_EN` defined, `Fault`=1 and no request; without it, `MemAddr`=0x100 and the access completes.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// Multicycle memory port: runs one handshaked access at a time and holds the IR and MDR.
// Optional MEM_PORT_ALIGN_CHECK_EN rejects misaligned requests instead of truncating the address.
module mem_port_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] Instr,
  output logic [DATA_W-1:0] MemData,
  output logic              Busy,
  output logic              Fault,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              dbgState
);

  // Handshake: MemReq rises with MemAddr/MemWdata/MemWe already stable and stays high
  // until the first cycle MemAck=1; that cycle completes the access and carries read data.
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               irLoad;
  logic [ADDR_W-1:0]  selAddr;
  logic [ADDR_W-1:0]  reqAddr;
  logic               misaligned;
  logic               oneReq;

  assign selAddr = IorD ? ALUOut : PC;
  assign oneReq  = MemRead ^ MemWrite;

`ifdef MEM_PORT_ALIGN_CHECK_EN
  assign misaligned = |selAddr[1:0];
  assign reqAddr    = selAddr;
`else
  // No check: the access is word-aligned by dropping the byte offset.
  assign misaligned = 1'b0;
  assign reqAddr    = selAddr & ~ADDR_W'(3);
`endif

  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      irLoad   <= 1'b0;
      Instr    <= '0;
      MemData  <= '0;
      Busy     <= 1'b0;
      Fault    <= 1'b0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((MemRead || MemWrite) && misaligned) begin
            Fault <= 1'b1;
          end else if (MemRead && MemWrite) begin
            Fault <= 1'b1;
          end else if (oneReq) begin
            MemAddr  <= reqAddr;
            MemWdata <= WriteData;
            MemWe    <= MemWrite;
            irLoad   <= IRWrite & MemRead;
            MemReq   <= 1'b1;
            Busy     <= 1'b1;
            cnt      <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (MemAck) begin
            if (!MemWe) begin
              MemData <= MemRdata;
              if (irLoad) Instr <= MemRdata;
            end
            MemReq <= 1'b0;
            Busy   <= 1'b0;
            MemWe  <= 1'b0;
            state  <= IDLE;
          end else if (cnt == CNT_LAST) begin
            Fault  <= 1'b1;
            MemReq <= 1'b0;
            Busy   <= 1'b0;
            MemWe  <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: directed plus randomized accesses checked against a
// transaction-level model of IR, MDR, Fault and access latency.
module tb_mem_port_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          IorD, MemRead, MemWrite, IRWrite;
  logic [AW-1:0] PC, ALUOut;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] Instr, MemData;
  logic          Busy, Fault, MemReq, MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWdata;
  logic          MemAck;
  logic [DW-1:0] MemRdata;
  logic          dbgState;

  mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
    .Instr(Instr), .MemData(MemData), .Busy(Busy), .Fault(Fault),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemAck(MemAck), .MemRdata(MemRdata), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard and model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mInstr, mMdr;
  logic          mFault;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PC        = '0;
    ALUOut    = '0;
    WriteData = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    MemAck   = 1'b0;
    MemRdata = '0;
    step();
    step();
    rst = 1'b0;
    mInstr = '0;
    mMdr   = '0;
    mFault = 1'b0;
    check("rst_instr", Instr, 0);
    check("rst_mdr", MemData, 0);
    check("rst_busy", Busy, 0);
    check("rst_fault", Fault, 0);
    check("rst_req", MemReq, 0);
    check("rst_we", MemWe, 0);
    check("rst_addr", MemAddr, 0);
    check("rst_wdata", MemWdata, 0);
  endtask

  // One access; k = no-ack cycles before the ack (k >= TO means never acked).
  task automatic access(input bit wr, input bit iord, input bit irw,
                        input logic [AW-1:0] pc, input logic [AW-1:0] alu,
                        input logic [DW-1:0] wd, input int k, input logic [DW-1:0] rdata);
    logic [AW-1:0] sel;
    logic [AW-1:0] expAddr;
    bit            reject;
    int            expCycles;
    int            busyCycles;
    sel = iord ? alu : pc;
    expAddr = {sel[AW-1:2], 2'b00};
`ifdef MEM_PORT_ALIGN_CHECK_EN
    reject = (sel[1:0] != 2'b00);
    expAddr = sel;
`else
    reject = 1'b0;
`endif
    MemRead = !wr; MemWrite = wr; IorD = iord; IRWrite = irw;
    PC = pc; ALUOut = alu; WriteData = wd;
    MemAck = 1'($urandom_range(0, 1));
    MemRdata = $urandom;
    step();
    clearInputs();
    MemAck = 1'b0;
    if (reject) begin
      mFault = 1'b1;
      check("rej_req", MemReq, 0);
      check("rej_busy", Busy, 0);
      check("rej_fault", Fault, mFault);
      return;
    end
    check("start_req", MemReq, 1);
    check("start_busy", Busy, 1);
    check("start_addr", MemAddr, expAddr);
    check("start_we", MemWe, wr);
    check("start_wdata", MemWdata, wd);
    expCycles = (k < TO) ? k + 1 : TO;
    busyCycles = 0;
    while (Busy === 1'b1 && busyCycles < TO + 2) begin
      busyCycles++;
      MemAck   = (busyCycles == k + 1);
      MemRdata = (busyCycles == k + 1) ? rdata : $urandom;
      // inputs during the wait must be ignored
      MemRead = 1'($urandom_range(0, 1)); MemWrite = 1'($urandom_range(0, 1));
      IorD = 1'($urandom_range(0, 1)); IRWrite = 1'($urandom_range(0, 1));
      PC = $urandom; ALUOut = $urandom; WriteData = $urandom;
      check("wait_addr", MemAddr, expAddr);
      check("wait_wdata", MemWdata, wd);
      check("wait_we", MemWe, wr);
      check("wait_req", MemReq, 1);
      step();
    end
    clearInputs();
    MemAck = 1'b0;
    if (k < TO && !wr) begin
      mMdr = rdata;
      if (irw) mInstr = rdata;
    end
    if (k >= TO) mFault = 1'b1;
    exp_q.push_back(mMdr);
    check("busy_cycles", busyCycles, expCycles);
    check("end_busy", Busy, 0);
    check("end_req", MemReq, 0);
    check("end_we", MemWe, 0);
    check("end_state", dbgState, 0);
    check("end_fault", Fault, mFault);
    check("end_instr", Instr, mInstr);
    check("end_mdr", MemData, exp_q.pop_front());
  endtask

  task automatic illegalBoth();
    MemRead = 1'b1; MemWrite = 1'b1; PC = 32'h80;
    step();
    clearInputs();
    mFault = 1'b1;
    check("ill_req", MemReq, 0);
    check("ill_busy", Busy, 0);
    check("ill_fault", Fault, mFault);
    check("ill_mdr", MemData, mMdr);
  endtask

  task automatic resetMidAccess();
    MemRead = 1'b1; IRWrite = 1'b1; PC = 32'h200;
    step();
    clearInputs();
    check("rma_req", MemReq, 1);
    step();
    rst = 1'b1; MemAck = 1'b1; MemRdata = 32'h12345678;
    step();
    rst = 1'b0; MemAck = 1'b0;
    mInstr = '0; mMdr = '0; mFault = 1'b0;
    check("rma_mdr", MemData, 0);
    check("rma_instr", Instr, 0);
    check("rma_req", MemReq, 0);
    check("rma_busy", Busy, 0);
    check("rma_state", dbgState, 0);
    check("rma_fault", Fault, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    doReset();
    // zero-wait instruction fetch
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 0, 32'h8C220004);
    // store with 3 wait cycles
    access(1'b1, 1'b1, 1'b0, 32'h0, 32'h100, 32'hDEADBEEF, 3, 32'h0);
    // data read without IR load, back-to-back
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 32'h0, 1, 32'hCAFEF00D);
    // timeout, then reset and ack in the last allowed cycle
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h108, 32'h0, TO, 32'h11111111);
    doReset();
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h10C, 32'h0, TO - 1, 32'h22222222);
    illegalBoth();
    doReset();
    resetMidAccess();
    // misaligned data read
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h102, 32'h0, 0, 32'h33333333);
    doReset();
    for (int i = 0; i < 30; i++) begin
      logic [AW-1:0] pc, alu;
      pc  = $urandom;
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        pc[1:0]  = 2'b00;
        alu[1:0] = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) illegalBoth();
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pc, alu, $urandom, $urandom_range(0, TO + 1), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
